// File: rtl/int_vector_ctrl.sv
// ============================================================================
// Module   : int_vector_ctrl
// Brief    : Edge-detected, fixed-priority interrupt controller with vectoring
//            and in-service tracking for the single-cycle MIPS core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_vector_ctrl #(
    parameter logic [31:0] VEC_BASE   = 32'h0000_01F0,
    parameter logic [31:0] VEC_STRIDE = 32'd4
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic [3:0]  done,
    input  logic        int_ack,
    input  logic        eoi,
    input  logic        mask_we,
    input  logic [3:0]  mask_wd,
    input  logic        ovf_clr,
    output logic        irq,
    output logic [31:0] int_addr,
    output logic [3:0]  pending,
    output logic [3:0]  mask,
    output logic [3:0]  in_service,
    output logic [3:0]  ovf
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_sel_id;
    logic [1:0] w_sel_nxt;
    logic [1:0] w_winner;

    logic [3:0] r_done_q;
    logic [3:0] r_pending;
    logic [3:0] r_mask;
    logic [3:0] r_in_service;
    logic [3:0] r_ovf;

    logic [3:0] w_event;
    logic [3:0] w_eligible;
    logic [3:0] w_sel_onehot;
    logic [3:0] w_ack_clr;
    logic [3:0] w_new_ovf;
    logic       w_ack_take;
    logic       w_eoi_take;

    assign w_event      = done & ~r_done_q;
    assign w_eligible   = r_pending & ~r_mask;
    assign w_sel_onehot = 4'b0001 << r_sel_id;
    assign w_ack_take   = (r_state == S_REQ) && int_ack;
    assign w_eoi_take   = (r_state == S_SERVICE) && eoi;
    assign w_ack_clr    = w_ack_take ? w_sel_onehot : 4'b0000;
    // A fresh event on a bit being acknowledged re-arms it rather than overflowing
    assign w_new_ovf    = w_event & r_pending & ~w_ack_clr;

    always_comb begin
        w_winner = 2'd3;
        if (w_eligible[0])      w_winner = 2'd0;
        else if (w_eligible[1]) w_winner = 2'd1;
        else if (w_eligible[2]) w_winner = 2'd2;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel_id;
        case (r_state)
            S_IDLE: begin
                if (w_eligible != 4'b0000) begin
                    w_sel_nxt   = w_winner;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (int_ack) w_state_nxt = S_SERVICE;
            end
            S_SERVICE: begin
                if (eoi) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_sel_id <= 2'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel_id <= w_sel_nxt;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_done_q     <= 4'b0000;
            r_pending    <= 4'b0000;
            r_mask       <= 4'b0000;
            r_in_service <= 4'b0000;
            r_ovf        <= 4'b0000;
        end else begin
            r_done_q  <= done;
            r_pending <= (r_pending & ~w_ack_clr) | w_event;
            r_ovf     <= (ovf_clr ? 4'b0000 : r_ovf) | w_new_ovf;
            if (mask_we) r_mask <= mask_wd;
            if (w_ack_take)      r_in_service <= w_sel_onehot;
            else if (w_eoi_take) r_in_service <= 4'b0000;
        end
    end

    assign irq        = (r_state == S_REQ);
    assign int_addr   = VEC_BASE + VEC_STRIDE * {30'd0, r_sel_id};
    assign pending    = r_pending;
    assign mask       = r_mask;
    assign in_service = r_in_service;
    assign ovf        = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_int_vector_ctrl.sv
// ============================================================================
// Module   : tb_int_vector_ctrl
// Brief    : Directed and randomized bench for int_vector_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_int_vector_ctrl;

    logic        Clk = 1'b0;
    logic        reset;
    logic [3:0]  done;
    logic        int_ack;
    logic        eoi;
    logic        mask_we;
    logic [3:0]  mask_wd;
    logic        ovf_clr;
    logic        irq;
    logic [31:0] int_addr;
    logic [3:0]  pending;
    logic [3:0]  mask;
    logic [3:0]  in_service;
    logic [3:0]  ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: controller phase 0=idle, 1=requesting, 2=servicing
    int         m_phase;
    int         m_sel;
    logic [3:0] m_done_q, m_pend, m_mask, m_isv, m_ovf;

    int_vector_ctrl dut (
        .Clk        (Clk),
        .reset      (reset),
        .done       (done),
        .int_ack    (int_ack),
        .eoi        (eoi),
        .mask_we    (mask_we),
        .mask_wd    (mask_wd),
        .ovf_clr    (ovf_clr),
        .irq        (irq),
        .int_addr   (int_addr),
        .pending    (pending),
        .mask       (mask),
        .in_service (in_service),
        .ovf        (ovf)
    );

    always #5 Clk = ~Clk;

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_sel = 0;
        m_done_q = 0; m_pend = 0; m_mask = 0; m_isv = 0; m_ovf = 0;
    endtask

    task automatic model_step();
        logic [3:0] ev, elig, clr;
        ev   = done & ~m_done_q;
        elig = m_pend & ~m_mask;
        clr  = (m_phase == 1 && int_ack) ? (4'b0001 << m_sel) : 4'b0000;
        m_ovf  = (ovf_clr ? 4'b0000 : m_ovf) | (ev & m_pend & ~clr);
        m_pend = (m_pend & ~clr) | ev;
        if (m_phase == 0 && elig != 0) begin
            m_sel = lowest(elig); m_phase = 1;
        end else if (m_phase == 1 && int_ack) begin
            m_isv = 4'b0001 << m_sel; m_phase = 2;
        end else if (m_phase == 2 && eoi) begin
            m_isv = 0; m_phase = 0;
        end
        if (mask_we) m_mask = mask_wd;
        m_done_q = done;
    endtask

    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drain();
        done = 0;
        for (int k = 0; k < 40 && !(m_phase == 0 && (m_pend & ~m_mask) == 0); k++) begin
            int_ack = (m_phase == 1);
            eoi     = (m_phase == 2);
            tick();
        end
        int_ack = 0; eoi = 0;
        n_checks++;
        if (!(m_phase == 0 && (m_pend & ~m_mask) == 0) || irq !== 1'b0) begin
            n_fail++; $display("FAIL drain: irq=%b pending=%b required idle with nothing eligible", irq, pending);
        end
    endtask

    task automatic test_reset();
        reset = 1; done = 0; int_ack = 0; eoi = 0; mask_we = 0; mask_wd = 0; ovf_clr = 0;
        model_reset();
        repeat (2) @(posedge Clk);
        #3 reset = 0;
        #1;
        n_checks++;
        if (irq !== 1'b0 || int_addr !== 32'h1F0) begin
            n_fail++; $display("FAIL reset_req: irq=%b addr=%h required 0/1f0", irq, int_addr);
        end
        n_checks++;
        if ({pending, mask, in_service, ovf} !== 16'h0) begin
            n_fail++; $display("FAIL reset_regs: pend=%b mask=%b isv=%b ovf=%b required all 0", pending, mask, in_service, ovf);
        end
    endtask

    task automatic test_single();
        done = 4'b0010; tick();
        n_checks++;
        if (pending !== 4'b0010 || irq !== 1'b0) begin
            n_fail++; $display("FAIL single_pend: pend=%b irq=%b required 0010/0", pending, irq);
        end
        tick();
        n_checks++;
        if (irq !== 1'b1 || int_addr !== 32'h1F4) begin
            n_fail++; $display("FAIL single_req: irq=%b addr=%h required 1/1f4", irq, int_addr);
        end
        int_ack = 1; tick(); int_ack = 0;
        n_checks++;
        if (pending !== 4'b0000 || in_service !== 4'b0010 || irq !== 1'b0) begin
            n_fail++; $display("FAIL single_ack: pend=%b isv=%b irq=%b required 0000/0010/0", pending, in_service, irq);
        end
        eoi = 1; tick(); eoi = 0;
        n_checks++;
        if (in_service !== 4'b0000 || irq !== 1'b0) begin
            n_fail++; $display("FAIL single_eoi: isv=%b irq=%b required 0000/0", in_service, irq);
        end
        drain();
    endtask

    task automatic test_priority();
        done = 4'b1001; tick(); tick();
        n_checks++;
        if (irq !== 1'b1 || int_addr !== 32'h1F0) begin
            n_fail++; $display("FAIL prio_first: irq=%b addr=%h required 1/1f0", irq, int_addr);
        end
        int_ack = 1; tick(); int_ack = 0;
        eoi = 1; tick(); eoi = 0;
        tick();
        n_checks++;
        if (irq !== 1'b1 || int_addr !== 32'h1FC) begin
            n_fail++; $display("FAIL prio_second: irq=%b addr=%h required 1/1fc", irq, int_addr);
        end
        drain();
    endtask

    task automatic test_overflow();
        done = 4'b0100; tick();
        done = 4'b0000; tick();
        done = 4'b0100; tick();
        n_checks++;
        if (ovf !== 4'b0100 || pending[2] !== 1'b1) begin
            n_fail++; $display("FAIL ovf_set: ovf=%b pend=%b required 0100/x1xx", ovf, pending);
        end
        ovf_clr = 1; tick(); ovf_clr = 0;
        n_checks++;
        if (ovf !== 4'b0000) begin
            n_fail++; $display("FAIL ovf_clr: ovf=%b required 0000", ovf);
        end
        done = 4'b0000; tick();
        done = 4'b0100; int_ack = 1; tick(); int_ack = 0;
        n_checks++;
        if (pending[2] !== 1'b1 || ovf !== 4'b0000 || in_service !== 4'b0100) begin
            n_fail++; $display("FAIL ack_and_set: pend=%b ovf=%b isv=%b required x1xx/0000/0100", pending, ovf, in_service);
        end
        drain();
    endtask

    task automatic test_mask();
        mask_we = 1; mask_wd = 4'b0001; done = 4'b0001; tick(); mask_we = 0;
        tick();
        n_checks++;
        if (pending[0] !== 1'b1 || irq !== 1'b0) begin
            n_fail++; $display("FAIL mask_block: pend=%b irq=%b required xxx1/0", pending, irq);
        end
        mask_we = 1; mask_wd = 4'b0000; tick(); mask_we = 0;
        n_checks++;
        if (irq !== 1'b0 || mask !== 4'b0000) begin
            n_fail++; $display("FAIL unmask_early: irq=%b mask=%b required 0/0000", irq, mask);
        end
        tick();
        n_checks++;
        if (irq !== 1'b1 || int_addr !== 32'h1F0) begin
            n_fail++; $display("FAIL unmask_req: irq=%b addr=%h required 1/1f0", irq, int_addr);
        end
        drain();
    endtask

    task automatic test_no_nesting();
        done = 4'b0010; tick(); tick();
        int_ack = 1; tick(); int_ack = 0;
        done = 4'b0011; tick();
        n_checks++;
        if (irq !== 1'b0 || pending !== 4'b0001) begin
            n_fail++; $display("FAIL nest_pend: irq=%b pend=%b required 0/0001", irq, pending);
        end
        tick(); tick();
        n_checks++;
        if (irq !== 1'b0 || in_service !== 4'b0010) begin
            n_fail++; $display("FAIL nest_hold: irq=%b isv=%b required 0/0010", irq, in_service);
        end
        eoi = 1; tick(); eoi = 0;
        n_checks++;
        if (irq !== 1'b0 || in_service !== 4'b0000) begin
            n_fail++; $display("FAIL nest_eoi: irq=%b isv=%b required 0/0000", irq, in_service);
        end
        tick();
        n_checks++;
        if (irq !== 1'b1 || int_addr !== 32'h1F0) begin
            n_fail++; $display("FAIL nest_rearb: irq=%b addr=%h required 1/1f0", irq, int_addr);
        end
        drain();
        int_ack = 1; tick(); int_ack = 0;
        n_checks++;
        if (irq !== 1'b0 || in_service !== 4'b0000 || pending !== 4'b0000) begin
            n_fail++; $display("FAIL ack_idle: irq=%b isv=%b pend=%b required 0/0000/0000", irq, in_service, pending);
        end
        done = 4'b0100; tick(); tick();
        eoi = 1; tick(); eoi = 0;
        n_checks++;
        if (irq !== 1'b1 || in_service !== 4'b0000 || int_addr !== 32'h1F8) begin
            n_fail++; $display("FAIL eoi_req: irq=%b isv=%b addr=%h required 1/0000/1f8", irq, in_service, int_addr);
        end
        drain();
    endtask

    task automatic test_async_reset();
        done = 4'b0010; tick(); tick();
        #2 reset = 1;
        #1;
        n_checks++;
        if (irq !== 1'b0 || int_addr !== 32'h1F0 || pending !== 4'b0000) begin
            n_fail++; $display("FAIL async_reset: irq=%b addr=%h pend=%b required 0/1f0/0000", irq, int_addr, pending);
        end
        model_reset();
        done = 4'b0000;
        #1 reset = 0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            done    = done ^ 4'($urandom & $urandom);
            int_ack = ($urandom % 3) == 0;
            eoi     = ($urandom % 4) == 0;
            mask_we = ($urandom % 16) == 0;
            mask_wd = 4'($urandom & $urandom);
            ovf_clr = ($urandom % 8) == 0;
            tick();
            n_checks++;
            if (irq !== (m_phase == 1)) begin
                n_fail++; $display("FAIL rnd_irq c=%0d: got %b required %b", c, irq, (m_phase == 1));
            end
            n_checks++;
            if (int_addr !== 32'h1F0 + 32'(4 * m_sel)) begin
                n_fail++; $display("FAIL rnd_addr c=%0d: got %h required %h", c, int_addr, 32'h1F0 + 32'(4 * m_sel));
            end
            n_checks++;
            if (pending !== m_pend || mask !== m_mask) begin
                n_fail++; $display("FAIL rnd_pend_mask c=%0d: got %b/%b required %b/%b", c, pending, mask, m_pend, m_mask);
            end
            n_checks++;
            if (in_service !== m_isv || ovf !== m_ovf) begin
                n_fail++; $display("FAIL rnd_isv_ovf c=%0d: got %b/%b required %b/%b", c, in_service, ovf, m_isv, m_ovf);
            end
        end
        int_ack = 0; eoi = 0; mask_we = 0; ovf_clr = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_overflow();
        test_mask();
        test_no_nesting();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/int_vector_ctrl.md
Name: int_vector_ctrl

Overview:
- Interrupt controller directly upstream of the single-cycle MIPS interrupt path.
- Turns the four peripheral completion lines (done1..done4) into pending events, arbitrates them by fixed priority, and presents one request plus its vector address to the core.
- Tracks the in-service source until the ISR's jepc retires.
- Replaces the raw OR of done lines as the core's interrupt input and supplies int_addr to the PC interrupt mux.

Parameters:
VEC_BASE, 32'h0000_01F0, byte address of vector for done1 (imem word 124)
VEC_STRIDE, 32'd4, byte spacing between consecutive vectors

Ports:
Clk  input  1  clock
reset  input  1  asynchronous, active-high reset
done  input  4  peripheral completion levels; bit0=done1 (highest priority) .. bit3=done4
int_ack  input  1  core accepted the interrupt this cycle (status_bit & irq)
eoi  input  1  end of interrupt; high for the cycle a jepc instruction executes
mask_we  input  1  write enable for mask register
mask_wd  input  4  new mask value; 1 = source disabled
ovf_clr  input  1  clears all overflow flags
irq  output  1  interrupt request to core
int_addr  output  32  vector address for current request
pending  output  4  pending event bits
mask  output  4  current mask register
in_service  output  4  one-hot source being serviced; 0 when none
ovf  output  4  sticky lost-event flags

Behaviour:
- Reset: reset is asynchronous, active-high; clock is Clk. All registers reset to 0: done_q, pending, mask, in_service, ovf, sel_id=0. State=IDLE, irq=0, int_addr=VEC_BASE.
- Edge detect: done_q <= done each cycle. An event on bit i is done[i] & ~done_q[i]. A line already high when reset releases produces one event in the first cycle.
- Pending: an event sets pending[i] on the next edge.
  - If pending[i] is already 1 and not being cleared that cycle, set ovf[i] instead.
  - A clear caused by ack and a new event in the same cycle: the set wins, pending stays 1, no ovf.
- ovf: sticky. ovf_clr zeroes it. A new overflow in the same cycle as ovf_clr wins.
- Mask: mask_we loads mask_wd at the clock edge. Masking does not clear pending; it only blocks arbitration.
- eligible = pending & ~mask. Winner is the lowest set index.
- FSM:
  - IDLE: if eligible != 0, latch sel_id = winner and go to REQ (irq rises one cycle after the pending bit is visible).
  - REQ: irq=1; sel_id frozen, even if a higher-priority source becomes pending or the selected source is masked.
    - On int_ack: clear pending[sel_id], set in_service = onehot(sel_id), go to SERVICE.
    - Without int_ack, stay in REQ indefinitely.
  - SERVICE: irq=0, no nesting. On eoi: in_service=0, go to IDLE. Re-arbitration happens from IDLE on the following cycle.
- int_addr = VEC_BASE + VEC_STRIDE*sel_id (32-bit, no wrap check). Combinational from sel_id; stable in REQ and SERVICE.
- Ignored inputs: int_ack outside REQ; eoi outside SERVICE.
- Latency:
  - done rise at edge N sets pending at edge N+1, enters REQ at N+2.
  - irq is high during the cycle after edge N+2.
- Reset mid-operation: returns immediately to reset values. Pending events are discarded.

Test Plan:
- Single source: raise done[1] → pending=4'b0010 after 1 edge; irq=1 and int_addr=32'h1F4 after 2 edges; pulse int_ack → pending=0, in_service=4'b0010, irq=0; pulse eoi → in_service=0, state IDLE.
- Priority: raise done[3] and done[0] in the same cycle → int_addr=32'h1F0. After ack+eoi, next request has int_addr=32'h1FC.
- Overflow / same-cycle set: toggle done[2] low then high while pending[2]=1 → ovf=4'b0100, pending[2] stays 1. ovf_clr → ovf=0. Event coinciding with ack of source 2 → pending[2]=1 after the ack.
- Mask: mask_wd=4'b0001 with done[0] rising → pending[0]=1, irq=0. Unmask → irq=1 two cycles later, int_addr=32'h1F0.
- No nesting / ignored handshakes: in SERVICE raise done[0] → irq stays 0 until eoi; int_ack while IDLE and eoi while REQ change nothing.
- Async reset in REQ: assert reset mid-cycle → irq=0, int_addr=32'h1F0, pending=0 immediately, without waiting for a Clk edge.
